// File: rtl/gerador_comandos_pkg.sv
// Shared types and defaults for the lighting-control command front end.
//   presenca_t        : presence FSM states
//   DEBOUNCE_DEFAULT  : default debounce hold, in synchronized cycles
//   OFF_DELAY_DEFAULT : default absence timeout, in synchronized cycles
package pkg_iluminacao;

    localparam int unsigned DEBOUNCE_DEFAULT  = 16;
    localparam int unsigned OFF_DELAY_DEFAULT = 64;

    typedef enum logic [1:0] {
        AUSENTE  = 2'd0,
        PRESENTE = 2'd1,
        ESPERA   = 2'd2
    } presenca_t;

endpackage

// File: rtl/gerador_comandos_if.sv
// Board-side bundle of the command generator.
//   btn_modo, btn_lamp, sensor : raw field inputs (asynchronous to clk)
//   a, b, c, d                 : single-cycle command pulses to the lighting FSM
//   master : the side driving the raw inputs and consuming the commands
//   slave  : the command generator itself
interface gerador_comandos_if;

    logic btn_modo;
    logic btn_lamp;
    logic sensor;
    logic a;
    logic b;
    logic c;
    logic d;

    modport master (
        output btn_modo,
        output btn_lamp,
        output sensor,
        input  a,
        input  b,
        input  c,
        input  d
    );

    modport slave (
        input  btn_modo,
        input  btn_lamp,
        input  sensor,
        output a,
        output b,
        output c,
        output d
    );

endinterface

// File: rtl/gerador_comandos_debounce_pulso.sv
// Synchronizes a raw pushbutton, debounces it and emits one registered pulse
// per accepted press (release is debounced but silent).
//   clk, rst : system clock, synchronous active-high reset
//   raw      : raw button level, asynchronous to clk
//   pulso    : one-cycle pulse the cycle after the debounced level rises
module debounce_pulso
    import pkg_iluminacao::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic pulso
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          s1;
    logic          s2;
    logic          stable;
    logic          stable_prev;
    logic [CW-1:0] cnt;

    // Two-flop synchronizer
    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= raw;
            s2 <= s1;
        end
    end

    // Level is accepted only after holding for DEBOUNCE_CYCLES consecutive cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            stable <= 1'b0;
            cnt    <= '0;
        end else if (s2 == stable) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            stable <= s2;
            cnt    <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    // Rising edge of the accepted level, registered
    always_ff @(posedge clk) begin
        if (rst) begin
            stable_prev <= 1'b0;
            pulso       <= 1'b0;
        end else begin
            stable_prev <= stable;
            pulso       <= stable & ~stable_prev;
        end
    end

endmodule

// File: rtl/gerador_comandos.sv
// Command front end for the lighting FSM: debounced button pulses (a, b) and
// presence/absence pulses (d, c) derived from a synchronized presence sensor.
//   clk, rst : system clock, synchronous active-high reset
//   bus      : raw inputs btn_modo/btn_lamp/sensor in, pulses a/b/c/d out
module gerador_comandos
    import pkg_iluminacao::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
    parameter int unsigned OFF_DELAY       = OFF_DELAY_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    gerador_comandos_if.slave  bus
);

    localparam int unsigned OW = $clog2(OFF_DELAY + 1);
    localparam logic [OW-1:0] OFF_LAST = OW'(OFF_DELAY);

    logic a_q;
    logic b_q;
    logic c_q;
    logic d_q;

    // Button pulses
    debounce_pulso #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_deb_modo (
        .clk   (clk),
        .rst   (rst),
        .raw   (bus.btn_modo),
        .pulso (a_q)
    );

    debounce_pulso #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_deb_lamp (
        .clk   (clk),
        .rst   (rst),
        .raw   (bus.btn_lamp),
        .pulso (b_q)
    );

    // Sensor synchronizer
    logic sens_s1;
    logic sens_s2;

    always_ff @(posedge clk) begin
        if (rst) begin
            sens_s1 <= 1'b0;
            sens_s2 <= 1'b0;
        end else begin
            sens_s1 <= bus.sensor;
            sens_s2 <= sens_s1;
        end
    end

    // Presence FSM state and registered pulses
    presenca_t     state_q;
    presenca_t     state_n;
    logic [OW-1:0] cnt_q;
    logic [OW-1:0] cnt_n;
    logic          c_n;
    logic          d_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= AUSENTE;
            cnt_q   <= '0;
            c_q     <= 1'b0;
            d_q     <= 1'b0;
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
            c_q     <= c_n;
            d_q     <= d_n;
        end
    end

    // Next state: d only leaving AUSENTE, c only leaving ESPERA, so they alternate
    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        c_n     = 1'b0;
        d_n     = 1'b0;
        case (state_q)
            AUSENTE: begin
                if (sens_s2) begin
                    state_n = PRESENTE;
                    d_n     = 1'b1;
                end
            end
            PRESENTE: begin
                if (!sens_s2) begin
                    state_n = ESPERA;
                    cnt_n   = OW'(1);
                end
            end
            ESPERA: begin
                if (sens_s2) begin
                    // Presence returned inside the hold window: lamp is still on
                    state_n = PRESENTE;
                    cnt_n   = '0;
                end else if (cnt_q == OFF_LAST) begin
                    state_n = AUSENTE;
                    cnt_n   = '0;
                    c_n     = 1'b1;
                end else begin
                    cnt_n = cnt_q + OW'(1);
                end
            end
            default: begin
                state_n = AUSENTE;
                cnt_n   = '0;
            end
        endcase
    end

    assign bus.a = a_q;
    assign bus.b = b_q;
    assign bus.c = c_q;
    assign bus.d = d_q;

endmodule

// File: tb/tb_gerador_comandos.sv
// Self-checking bench for gerador_comandos (DEBOUNCE_CYCLES=4, OFF_DELAY=8).
// Expected pulses (kind + edge number) are queued when stimulus is driven and
// matched by a monitor whenever any output is high.
module tb_gerador_comandos;
    import pkg_iluminacao::*;

    localparam int unsigned DEB = 4;
    localparam int unsigned OFF = 8;

    typedef struct {
        byte         kind;
        int unsigned ciclo;
    } exp_t;

    logic        clk;
    logic        rst;
    int unsigned cyc;
    int unsigned n_checks;
    int unsigned n_pass;
    exp_t        q[$];

    gerador_comandos_if bus ();

    gerador_comandos #(
        .DEBOUNCE_CYCLES (DEB),
        .OFF_DELAY       (OFF)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every high output must match the next queued expectation
    always @(negedge clk) begin
        logic [3:0] obs;
        byte        k;
        exp_t       e;
        obs = {bus.a, bus.b, bus.c, bus.d};
        for (int i = 0; i < 4; i++) begin
            if (obs[3-i] !== 1'b0) begin
                k = (i == 0) ? "a" : (i == 1) ? "b" : (i == 2) ? "c" : "d";
                n_checks++;
                if (q.size() == 0) begin
                    $display("FAIL unexpected_%c: got pulse at edge %0d, required none", k, cyc);
                end else begin
                    e = q.pop_front();
                    if (e.kind !== k || e.ciclo !== cyc)
                        $display("FAIL pulse_%c: got %c at edge %0d, required %c at edge %0d",
                                 k, k, cyc, e.kind, e.ciclo);
                    else
                        n_pass++;
                end
            end
        end
    end

    task automatic expect_pulse(input byte kind, input int unsigned lat);
        exp_t e;
        e.kind  = kind;
        e.ciclo = cyc + lat;
        q.push_back(e);
    endtask

    task automatic test_reset();
        rst          = 1'b1;
        bus.btn_modo = 1'b1;
        bus.btn_lamp = 1'b1;
        bus.sensor   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if ({bus.a, bus.b, bus.c, bus.d} !== 4'b0000)
                $display("FAIL reset_outputs: got %b, required 0000", {bus.a, bus.b, bus.c, bus.d});
            else
                n_pass++;
        end
        rst          = 1'b0;
        bus.btn_modo = 1'b0;
        bus.btn_lamp = 1'b0;
        bus.sensor   = 1'b0;
        repeat (15) @(negedge clk);
        n_checks++;
        if (dut.state_q !== AUSENTE)
            $display("FAIL reset_state: got %0d, required %0d", dut.state_q, AUSENTE);
        else
            n_pass++;
        n_checks++;
        if (q.size() != 0)
            $display("FAIL reset_pending: got %0d outstanding, required 0", q.size());
        else
            n_pass++;
    endtask

    task automatic test_clean_press();
        @(negedge clk);
        expect_pulse("a", DEB + 3);
        bus.btn_modo = 1'b1;
        repeat (20) @(negedge clk);
        bus.btn_modo = 1'b0;
        repeat (20) @(negedge clk);
        n_checks++;
        if (q.size() != 0)
            $display("FAIL clean_press_pending: got %0d outstanding, required 0", q.size());
        else
            n_pass++;
    endtask

    task automatic test_bounce();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus.btn_lamp = (i % 2 == 0);
        end
        @(negedge clk);
        expect_pulse("b", DEB + 3);
        bus.btn_lamp = 1'b1;
        repeat (10) @(negedge clk);
        bus.btn_lamp = 1'b0;
        repeat (15) @(negedge clk);
        n_checks++;
        if (q.size() != 0)
            $display("FAIL bounce_pending: got %0d outstanding, required 0", q.size());
        else
            n_pass++;
    endtask

    task automatic test_presence_timeout();
        @(negedge clk);
        expect_pulse("d", 3);
        bus.sensor = 1'b1;
        repeat (5) @(negedge clk);
        expect_pulse("c", OFF + 3);
        bus.sensor = 1'b0;
        repeat (20) @(negedge clk);
        n_checks++;
        if (q.size() != 0)
            $display("FAIL presence_pending: got %0d outstanding, required 0", q.size());
        else
            n_pass++;
        n_checks++;
        if (dut.state_q !== AUSENTE)
            $display("FAIL presence_state: got %0d, required %0d", dut.state_q, AUSENTE);
        else
            n_pass++;
    endtask

    task automatic test_reentry();
        @(negedge clk);
        expect_pulse("d", 3);
        bus.sensor = 1'b1;
        repeat (5) @(negedge clk);
        bus.sensor = 1'b0;
        repeat (5) @(negedge clk);
        bus.sensor = 1'b1;
        repeat (5) @(negedge clk);
        expect_pulse("c", OFF + 3);
        bus.sensor = 1'b0;
        repeat (20) @(negedge clk);
        n_checks++;
        if (q.size() != 0)
            $display("FAIL reentry_pending: got %0d outstanding, required 0", q.size());
        else
            n_pass++;
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        bus.btn_modo = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        expect_pulse("a", DEB + 3);
        repeat (20) @(negedge clk);
        bus.btn_modo = 1'b0;
        repeat (20) @(negedge clk);
        n_checks++;
        if (q.size() != 0)
            $display("FAIL reset_mid_pending: got %0d outstanding, required 0", q.size());
        else
            n_pass++;
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        expect_pulse("a", DEB + 3);
        expect_pulse("b", DEB + 3);
        bus.btn_modo = 1'b1;
        bus.btn_lamp = 1'b1;
        repeat (12) @(negedge clk);
        bus.btn_modo = 1'b0;
        bus.btn_lamp = 1'b0;
        repeat (15) @(negedge clk);
        n_checks++;
        if (q.size() != 0)
            $display("FAIL back_to_back_pending: got %0d outstanding, required 0", q.size());
        else
            n_pass++;
    endtask

    initial begin
        cyc          = 0;
        n_checks     = 0;
        n_pass       = 0;
        rst          = 1'b1;
        bus.btn_modo = 1'b1;
        bus.btn_lamp = 1'b1;
        bus.sensor   = 1'b1;
        test_reset();
        test_clean_press();
        test_bounce();
        test_presence_timeout();
        test_reentry();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/gerador_comandos.md
Name: gerador_comandos

Overview:
- Front end that produces the four command inputs (a, b, c, d) consumed by the lighting-control FSM.
- Conditions raw field inputs into clean single-cycle command pulses:
  - mode pushbutton -> a
  - manual lamp-toggle pushbutton -> b
  - presence sensor -> d (presence) and c (absence timeout)
- Sits between board pins and the lighting FSM; its outputs wire directly to that FSM's a/b/c/d.

Parameters:
- DEBOUNCE_CYCLES, 16, consecutive synchronized cycles a button level must hold before it is accepted (>=1).
- OFF_DELAY, 64, consecutive synchronized cycles of sensor low before c is issued (>=1).

Ports:
- clk  input  1  system clock; sole clock domain.
- rst  input  1  synchronous, active-high reset.
- btn_modo  input  1  raw mode pushbutton, active-high, asynchronous to clk.
- btn_lamp  input  1  raw manual-toggle pushbutton, active-high, asynchronous to clk.
- sensor  input  1  raw presence sensor level, 1 = presence, asynchronous to clk.
- a  output  1  one-cycle pulse: toggle auto/manual mode.
- b  output  1  one-cycle pulse: toggle lamp in manual mode.
- c  output  1  one-cycle pulse: absence timeout, lamp off in auto mode.
- d  output  1  one-cycle pulse: presence detected, lamp on in auto mode.

Behaviour:
- Reset
  - Synchronous, active-high, sampled on posedge clk.
  - All synchronizer flops, debounce stable levels and counters clear to 0.
  - Presence FSM goes to AUSENTE.
  - a, b, c, d = 0 while rst is high and in the first cycle after release.
  - Reset mid-operation aborts any count in progress; no pulse is emitted for it.
- Synchronization
  - Each raw input passes through a 2-flop synchronizer (s1 -> s2).
  - All downstream logic uses s2 only.
- Debounce (one instance per button)
  - Registers: stable level, counter of width $clog2(DEBOUNCE_CYCLES+1).
  - If s2 == stable: counter <= 0.
  - If s2 != stable and counter == DEBOUNCE_CYCLES-1: stable <= s2, counter <= 0.
  - Otherwise: counter increments.
  - Any glitch shorter than DEBOUNCE_CYCLES cycles resets the counter and is never accepted.
  - Pulse output (registered) is 1 for exactly the one cycle after stable goes 0->1.
  - Release (1->0) is debounced identically but produces no pulse.
  - Holding the button produces one pulse only.
  - Latency: pulse high DEBOUNCE_CYCLES+3 edges after the first edge sampling raw high.
  - a = pulse from btn_modo; b = pulse from btn_lamp.
  - a and b are independent and may coincide; the consumer gives a priority.
- Presence FSM (states AUSENTE, PRESENTE, ESPERA; counter width $clog2(OFF_DELAY+1))
  - AUSENTE: s2=1 -> PRESENTE, d=1 for one cycle.
  - PRESENTE: s2=0 -> ESPERA, counter <= 1.
  - ESPERA:
    - s2=1 -> PRESENTE, no pulse (lamp is already on).
    - s2=0 and counter == OFF_DELAY -> AUSENTE, c=1 for one cycle.
    - Otherwise counter increments.
  - With OFF_DELAY=1, c fires on the cycle after entering ESPERA.
  - c and d are never high in the same cycle.
  - d is issued only from AUSENTE; c only from ESPERA.
  - Strict alternation: d, c, d, c, ...
  - Latency: d high 3 edges after the first edge sampling raw sensor high.
  - Latency: c high OFF_DELAY+3 edges after the first edge sampling raw sensor low, if the sensor stays low.
- Outputs are all registered; no combinational path from input to output.
- Illegal FSM encoding -> AUSENTE, no pulse.

Decomposition:
- Shared package pkg_iluminacao:
  - presenca_t enum {AUSENTE, PRESENTE, ESPERA}.
  - Default constants DEBOUNCE_DEFAULT=16, OFF_DELAY_DEFAULT=64.
- Sub-module debounce_pulso:
  - Parameter DEBOUNCE_CYCLES; ports clk, rst, raw, pulso.
  - Contains the synchronizer, debounce and rising-edge pulse.
  - Instantiated twice, for btn_modo and btn_lamp.
- The presence FSM and its synchronizer live in the top module.

Test Plan (DEBOUNCE_CYCLES=4, OFF_DELAY=8):
- Reset: hold rst 3 cycles with all inputs high, release with inputs low -> a=b=c=d=0 throughout; FSM in AUSENTE.
- Clean press: btn_modo high 20 cycles -> a high exactly 1 cycle, 7 edges after the first sample; b, c, d stay 0; no second pulse on release.
- Bounce: btn_lamp toggles 1,0,1,0 each cycle, then holds high 10 cycles -> exactly one b pulse, 7 edges after the start of the stable hold.
- Presence then timeout: sensor 0->1 for 5 cycles then 0 -> d pulse 3 edges after the rise; c pulse 11 edges after the fall; exactly one of each.
- Re-entry: sensor low 5 cycles (inside the hold window), then high again -> no c and no second d; later low for 8+ cycles -> single c.
- Reset mid-operation: btn_modo held 3 cycles, rst for 1 cycle, button kept high -> no a before rst; one a pulse 7 edges after the first post-reset sample.
